mux_4_1_str: RTL and testbench
==============================

MUX_4_1_STR -- requirements
Module: mux_4_1_str

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the bit width of data inputs a, b, c, d and outputs y, y_q.

Ports (name  direction  width  meaning):
REQ-002 The block SHALL have port clk  input  1  single clock; all sequential logic on the rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port a  input  WIDTH  data input 0, selected when {s1,s0}=2'b00.
REQ-005 The block SHALL have port b  input  WIDTH  data input 1, selected when {s1,s0}=2'b01.
REQ-006 The block SHALL have port c  input  WIDTH  data input 2, selected when {s1,s0}=2'b10.
REQ-007 The block SHALL have port d  input  WIDTH  data input 3, selected when {s1,s0}=2'b11.
REQ-008 The block SHALL have port s1  input  1  select MSB.
REQ-009 The block SHALL have port s0  input  1  select LSB.
REQ-010 The block SHALL have port y  output  WIDTH  combinational mux output.
REQ-011 The block SHALL have port y_q  output  WIDTH  registered copy of y.
REQ-012 The port list SHALL be ordered clk, rst, a, b, c, d, s1, s0, y, y_q; the data ports keep the relative order a, b, c, d, s1, s0, y.

Function
REQ-013 y SHALL equal a, b, c or d for {s1,s0} = 00, 01, 10, 11 respectively, per bit, with zero clock latency.
REQ-014 y SHALL be built structurally from gate primitives: two inverters (~s1, ~s0), four 3-input AND terms per bit (data AND decoded select), and one 4-input OR per bit.
REQ-015 The structural slice SHALL be replicated per bit for WIDTH > 1; behavioural case or ternary selection SHALL NOT be used for y.
REQ-016 y SHALL be purely combinational: it SHALL NOT depend on clk or rst, and SHALL respond to any change of a, b, c, d, s1 or s0 without waiting for a clock edge.
REQ-017 y_q SHALL load y on every rising clk edge when rst=0, giving exactly one cycle of latency.
REQ-018 Exactly one AND term per bit SHALL be enabled for any known select value; the decoded selects SHALL be one-hot.
REQ-019 A select change and a data change in the same instant SHALL produce y equal to the new data on the newly selected input.
REQ-020 Inputs on unselected channels SHALL have no effect on y or y_q.

Reset
REQ-021 When rst=1 at a rising clk edge, y_q SHALL become all-zeros on that edge.
REQ-022 While rst=1, y_q SHALL stay zero on every edge; y SHALL continue to follow REQ-013.
REQ-023 On the first rising edge with rst=0, y_q SHALL load the current y.
REQ-024 Asserting rst mid-operation SHALL clear y_q on the next edge and SHALL have no other effect.
REQ-025 The block SHALL hold no state other than y_q.

Verification
REQ-026 a=0, b=1, c=1, d=0, s1=0, s0=1 -> y=1 (b selected), with no clock required.
REQ-027 a=1, b=0, c=0, d=1, s1=1, s0=0 -> y=0 (c selected); after one rising clk edge with rst=0 -> y_q=0.
REQ-028 Exhaustive sweep of all 64 combinations of a, b, c, d, s1, s0 (WIDTH=1) -> y equals the input picked by {s1,s0} in every case.
REQ-029 Hold a=1, b=0, c=1, d=0 and step {s1,s0} through 00, 01, 10, 11 -> y=1, 0, 1, 0, with y_q matching one clk edge later.
REQ-030 rst=1 for two edges while y=1 -> y_q=0 throughout; release rst -> y_q=1 after the first edge.
REQ-031 WIDTH=4, a=4'hA, b=4'h5, c=4'hF, d=4'h0, {s1,s0}=10 -> y=4'hF; change to 11 -> y=4'h0.

Source files
------------

// File: rtl/mux_4_1_str.sv
// 4:1 multiplexer built from gate primitives, replicated per bit.
// It has a combinational output y and a registered copy y_q.
module mux_4_1_str #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             s1,
  input  logic             s0,
  output wire  [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q
);

  wire s1_n;
  wire s0_n;

  not u_inv_s1 (s1_n, s1);
  not u_inv_s0 (s0_n, s0);

  // Each slice ANDs one data bit with one decoded select term, then ORs the four terms.
  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    wire t0;
    wire t1;
    wire t2;
    wire t3;
    and u_and0 (t0, a[i], s1_n, s0_n);
    and u_and1 (t1, b[i], s1_n, s0);
    and u_and2 (t2, c[i], s1,   s0_n);
    and u_and3 (t3, d[i], s1,   s0);
    or  u_or   (y[i], t0, t1, t2, t3);
  end

  logic [WIDTH-1:0] y_q_d;
  assign y_q_d = y;

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) y_q <= '0;
    else     y_q <= y_q_d;
  end

endmodule

// File: tb/tb_mux_4_1_str.sv
// Directed bench for mux_4_1_str: WIDTH=1 vector table and sweep, reset sequences, WIDTH=4 case.
module tb_mux_4_1_str;

  logic clk = 1'b0;
  logic rst;
  logic a1, b1, c1, d1;
  logic s1, s0;
  wire  y1;
  wire  yq1;
  logic [3:0] a4, b4, c4, d4;
  logic t1, t0;
  wire  [3:0] y4;
  wire  [3:0] yq4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_4_1_str #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .d(d1),
    .s1(s1), .s0(s0), .y(y1), .y_q(yq1)
  );

  mux_4_1_str #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .c(c4), .d(d4),
    .s1(t1), .s0(t0), .y(y4), .y_q(yq4)
  );

  typedef struct {
    logic       a, b, c, d;
    logic [1:0] sel;
    logic       y;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{a:1'b0, b:1'b1, c:1'b1, d:1'b0, sel:2'b01, y:1'b1};
    vecs[1] = '{a:1'b1, b:1'b0, c:1'b0, d:1'b1, sel:2'b10, y:1'b0};
    vecs[2] = '{a:1'b1, b:1'b0, c:1'b1, d:1'b0, sel:2'b00, y:1'b1};
    vecs[3] = '{a:1'b1, b:1'b0, c:1'b1, d:1'b0, sel:2'b01, y:1'b0};
    vecs[4] = '{a:1'b1, b:1'b0, c:1'b1, d:1'b0, sel:2'b10, y:1'b1};
    vecs[5] = '{a:1'b1, b:1'b0, c:1'b1, d:1'b0, sel:2'b11, y:1'b0};
    vecs[6] = '{a:1'b0, b:1'b0, c:1'b0, d:1'b1, sel:2'b11, y:1'b1};
    vecs[7] = '{a:1'b0, b:1'b1, c:1'b1, d:1'b1, sel:2'b00, y:1'b0};

    rst = 1'b1;
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b0; d1 = 1'b0; s1 = 1'b0; s0 = 1'b0;
    a4 = 4'hA; b4 = 4'h5; c4 = 4'hF; d4 = 4'h0; t1 = 1'b0; t0 = 1'b0;

    // Reset held for two edges while y=1
    step();
    chk("reset_y_follows", {3'b0, y1}, 4'h1);
    chk("reset_yq1_edge1", {3'b0, yq1}, 4'h0);
    chk("reset_yq4_edge1", yq4, 4'h0);
    step();
    chk("reset_yq1_edge2", {3'b0, yq1}, 4'h0);
    rst = 1'b0;
    step();
    chk("release_yq1", {3'b0, yq1}, 4'h1);
    chk("release_yq4", yq4, 4'hA);

    // Table vectors: combinational y, then y_q one edge later
    for (int i = 0; i < 8; i++) begin
      a1 = vecs[i].a; b1 = vecs[i].b; c1 = vecs[i].c; d1 = vecs[i].d;
      {s1, s0} = vecs[i].sel;
      #1;
      chk($sformatf("vec%0d_y", i), {3'b0, y1}, {3'b0, vecs[i].y});
      step();
      chk($sformatf("vec%0d_yq", i), {3'b0, yq1}, {3'b0, vecs[i].y});
    end

    // Exhaustive WIDTH=1 sweep, no clock needed
    for (int i = 0; i < 64; i++) begin
      logic [5:0] v;
      logic [3:0] dat;
      v = i[5:0];
      {a1, b1, c1, d1, s1, s0} = v;
      dat = {v[2], v[3], v[4], v[5]};
      #1;
      chk($sformatf("sweep%0d", i), {3'b0, y1}, {3'b0, dat[v[1:0]]});
    end

    // Simultaneous select and data change
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b0; d1 = 1'b1; s1 = 1'b0; s0 = 1'b0;
    #1;
    chk("simul_before", {3'b0, y1}, 4'h1);
    s1 = 1'b1; s0 = 1'b1; d1 = 1'b0;
    #1;
    chk("simul_after", {3'b0, y1}, 4'h0);

    // Reset asserted mid-operation
    a1 = 1'b1; s1 = 1'b0; s0 = 1'b0;
    step();
    chk("mid_pre", {3'b0, yq1}, 4'h1);
    rst = 1'b1;
    step();
    chk("mid_rst_yq", {3'b0, yq1}, 4'h0);
    chk("mid_rst_y", {3'b0, y1}, 4'h1);
    rst = 1'b0;
    step();
    chk("mid_release_yq", {3'b0, yq1}, 4'h1);

    // WIDTH=4 selection
    t1 = 1'b1; t0 = 1'b0;
    #1;
    chk("w4_sel10", y4, 4'hF);
    t0 = 1'b1;
    #1;
    chk("w4_sel11", y4, 4'h0);
    step();
    chk("w4_yq_sel11", yq4, 4'h0);
    t1 = 1'b0; t0 = 1'b0;
    #1;
    chk("w4_sel00", y4, 4'hA);
    t0 = 1'b1;
    #1;
    chk("w4_sel01", y4, 4'h5);
    step();
    chk("w4_yq_sel01", yq4, 4'h5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
